// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate defaults, bit-period derivation
// common to tx and rx, and the receiver state encoding.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 100_000_000;
  localparam int unsigned DEF_BAUD_RATE = 1_152_000;

  function automatic int unsigned bit_period(
    input int unsigned clk_freq,
    input int unsigned baud
  );
    return clk_freq / baud;
  endfunction

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous pad input.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry holding register.
// Ports: clk, rst, rx_i, ready_i, clr_err_i -> data_o, valid_o, frame_err_o, overrun_o, busy_o.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       ready_i,
  input  logic       clr_err_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned BIT_PERIOD  = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
  localparam logic [15:0] BIT_LAST    = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_LAST   = 16'(HALF_PERIOD - 1);

  rx_state_e   state;
  logic [15:0] clk_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        rx_s;

  logic stop_hit;
  logic deliver;
  logic frame_ev;
  logic overrun_ev;
  logic accept;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_i),
    .q   (rx_s)
  );

  assign stop_hit   = (state == RX_STOP) && (clk_cnt == BIT_LAST);
  assign deliver    = stop_hit & rx_s;
  assign frame_ev   = stop_hit & ~rx_s;
  assign accept     = valid_o & ready_i;
  assign overrun_ev = deliver & valid_o & ~ready_i;
  assign busy_o     = (state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RX_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      unique case (state)
        RX_IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            // line back high at mid start bit: treat as noise
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            // fill from the top so the first bit ends up in bit 0
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= rx_s ? RX_IDLE : RX_BREAK;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        RX_BREAK: begin
          clk_cnt <= '0;
          if (rx_s) state <= RX_IDLE;
        end
        default: begin
          state   <= RX_IDLE;
          clk_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (deliver && (!valid_o || ready_i)) begin
        data_o  <= shift;
        valid_o <= 1'b1;
      end else if (accept) begin
        valid_o <= 1'b0;
      end

      if (frame_ev)       frame_err_o <= 1'b1;
      else if (clr_err_i) frame_err_o <= 1'b0;

      if (overrun_ev)     overrun_o <= 1'b1;
      else if (clr_err_i) overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 86 clk/bit.
// Drives frames on rx_i and logs every accepted byte.
module tb_uart_rx;

  localparam int BP = 86;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i;
  logic       ready_i;
  logic       clr_err_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;
  logic [7:0] rx_q[$];

  uart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .ready_i     (ready_i),
    .clr_err_i   (clr_err_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst && valid_o && ready_i) rx_q.push_back(data_o);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = f[i];
      tick(BP);
    end
  endtask

  task automatic wait_valid(input int max, output logic ok);
    int n;
    n  = 0;
    ok = valid_o;
    while (!ok && n < max) begin
      tick(1);
      n++;
      ok = valid_o;
    end
  endtask

  task automatic wait_q(input int sz, input int max, output logic ok);
    int n;
    n = 0;
    while (rx_q.size() < sz && n < max) begin
      tick(1);
      n++;
    end
    ok = (rx_q.size() >= sz);
  endtask

  initial begin
    string      msg;
    int         q0;
    int         t0;
    int         lat;
    logic       ok;
    logic [7:0] b;

    rst       = 1'b1;
    rx_i      = 1'b1;
    ready_i   = 1'b0;
    clr_err_i = 1'b0;
    tick(5);
    chk("rst_data",  data_o,      0);
    chk("rst_valid", valid_o,     0);
    chk("rst_ferr",  frame_err_o, 0);
    chk("rst_ovr",   overrun_o,   0);
    chk("rst_busy",  busy_o,      0);
    rst = 1'b0;
    tick(10);

    // single byte
    ready_i = 1'b1;
    q0  = rx_q.size();
    lat = 0;
    ok  = 1'b0;
    fork
      send_frame(8'h48, 1'b1);
      begin
        t0 = cyc;
        wait_q(q0 + 1, 1200, ok);
        lat = cyc - t0;
      end
    join
    tick(50);
    chk("t1_seen", ok, 1);
    chk("t1_lat",  (lat >= 815 && lat <= 825), 1);
    chk("t1_qsz",  rx_q.size(), q0 + 1);
    chk("t1_data", (rx_q.size() > q0) ? rx_q[q0] : 8'hxx, 8'h48);
    chk("t1_flags", {frame_err_o, overrun_o}, 0);

    // back-to-back with held byte
    ready_i = 1'b0;
    q0 = rx_q.size();
    fork
      begin
        send_frame(8'h41, 1'b1);
        send_frame(8'h5A, 1'b1);
      end
      begin
        wait_valid(1200, ok);
        chk("t2_v1", ok, 1);
        chk("t2_d1", data_o, 8'h41);
        tick(200);
        chk("t2_hold", {valid_o, data_o}, {1'b1, 8'h41});
        ready_i = 1'b1;
      end
    join
    wait_q(q0 + 2, 300, ok);
    chk("t2_qsz", rx_q.size(), q0 + 2);
    chk("t2_b0", (rx_q.size() > q0) ? rx_q[q0] : 8'hxx, 8'h41);
    chk("t2_b1", (rx_q.size() > q0 + 1) ? rx_q[q0 + 1] : 8'hxx, 8'h5A);
    chk("t2_ovr", overrun_o, 0);

    // glitch reject
    q0 = rx_q.size();
    rx_i = 1'b0;
    tick(10);
    chk("t3_busy_hi", busy_o, 1);
    tick(10);
    rx_i = 1'b1;
    tick(100);
    chk("t3_busy_lo", busy_o, 0);
    chk("t3_valid", valid_o, 0);
    chk("t3_flags", {frame_err_o, overrun_o}, 0);
    chk("t3_qsz", rx_q.size(), q0);

    // framing error with line held low
    q0 = rx_q.size();
    send_frame(8'h55, 1'b0);
    tick(2000);
    chk("t4_ferr", frame_err_o, 1);
    chk("t4_busy", busy_o, 1);
    chk("t4_qsz", rx_q.size(), q0);
    rx_i = 1'b1;
    tick(5);
    chk("t4_idle", busy_o, 0);
    clr_err_i = 1'b1;
    tick(1);
    clr_err_i = 1'b0;
    chk("t4_clr", frame_err_o, 0);

    // overrun
    ready_i = 1'b0;
    q0 = rx_q.size();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(20);
    chk("t5_valid", valid_o, 1);
    chk("t5_data", data_o, 8'h11);
    chk("t5_ovr", overrun_o, 1);
    ready_i = 1'b1;
    tick(2);
    chk("t5_drop", valid_o, 0);
    chk("t5_qsz", rx_q.size(), q0 + 1);
    chk("t5_byte", (rx_q.size() > q0) ? rx_q[q0] : 8'hxx, 8'h11);
    clr_err_i = 1'b1;
    tick(1);
    clr_err_i = 1'b0;
    chk("t5_clr", overrun_o, 0);

    // loopback-style string, no idle gaps
    msg = "Hello! RISC-V!\n";
    q0 = rx_q.size();
    for (int i = 0; i < msg.len(); i++) send_frame(msg[i], 1'b1);
    wait_q(q0 + 15, 300, ok);
    chk("t6_qsz", rx_q.size(), q0 + 15);
    for (int i = 0; i < 15; i++) begin
      b = msg[i];
      chk($sformatf("t6_b%0d", i),
          (rx_q.size() > q0 + i) ? rx_q[q0 + i] : 8'hxx, b);
    end

    // reset in the middle of a frame
    rx_i = 1'b0;
    tick(400);
    chk("t7_busy_pre", busy_o, 1);
    rst  = 1'b1;
    rx_i = 1'b1;
    tick(2);
    chk("t7_data", data_o, 0);
    chk("t7_valid", valid_o, 0);
    chk("t7_flags", {frame_err_o, overrun_o}, 0);
    chk("t7_busy", busy_o, 0);
    rst = 1'b0;
    tick(200);
    q0 = rx_q.size();
    chk("t7_none", valid_o, 0);
    send_frame(8'hA5, 1'b1);
    wait_q(q0 + 1, 200, ok);
    chk("t7_qsz", rx_q.size(), q0 + 1);
    chk("t7_a5", (rx_q.size() > q0) ? rx_q[q0] : 8'hxx, 8'hA5);
    chk("t7_ferr", frame_err_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
